// File: rtl/m_axis_cq_adapt_128b_pkg.sv
// Shared definitions for the CQ adapter: request-type codes, fmt/type bytes,
// descriptor field offsets and the register-slice beat layout.
package m_axis_cq_adapt_128b_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } cq_state_e;

    // Core request-type codes (descriptor [78:75])
    localparam logic [3:0] REQ_MEM_RD    = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR    = 4'b0001;
    localparam logic [3:0] REQ_LOCKED_RD = 4'b0111;

    // TLP fmt/type bytes for the 4-DW (64-bit address) header form
    localparam logic [7:0] FMT_MEM_RD    = 8'h20;
    localparam logic [7:0] FMT_MEM_WR    = 8'h60;
    localparam logic [7:0] FMT_LOCKED_RD = 8'h21;

    // Descriptor field bit offsets
    localparam int DESC_ADDR_LSB  = 2;
    localparam int DESC_DWCNT_LSB = 64;
    localparam int DESC_TYPE_LSB  = 75;
    localparam int DESC_REQID_LSB = 80;
    localparam int DESC_TAG_LSB   = 96;
    localparam int DESC_BAR_LSB   = 112;
    localparam int DESC_TC_LSB    = 121;
    localparam int DESC_ATTR_LSB  = 124;

    // One beat as carried through the input slice: {discontinue, be, keep, data}
    typedef struct packed {
        logic         disc;
        logic [7:0]   be;
        logic [3:0]   keep;
        logic [127:0] data;
    } slice_beat_t;

    // Returns {supported, fmt_type} for a core request type
    function automatic logic [8:0] decode_type(input logic [3:0] req_type);
        case (req_type)
            REQ_MEM_RD:    return {1'b1, FMT_MEM_RD};
            REQ_MEM_WR:    return {1'b1, FMT_MEM_WR};
            REQ_LOCKED_RD: return {1'b1, FMT_LOCKED_RD};
            default:       return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/axis_iff.sv
// Single-entry AXI-stream register slice. Accepts a new beat whenever it is
// empty or its current beat leaves in the same cycle, so back-to-back beats
// flow at full rate. Ready is held low while reset is asserted.
module axis_iff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_eop,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_eop,
    output logic         m_valid,
    input  logic         m_ready
);

    logic         valid_q, valid_d;
    logic         eop_q, eop_d;
    logic [W-1:0] data_q, data_d;

    // Load a new beat when the slot is free or being drained this cycle
    always_comb begin
        s_ready = ~rst & (~valid_q | m_ready);
        valid_d = valid_q;
        eop_d   = eop_q;
        data_d  = data_q;
        if (s_ready) begin
            valid_d = s_valid;
            if (s_valid) begin
                eop_d  = s_eop;
                data_d = s_data;
            end
        end
    end

    // Slice storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
        end
    end

    assign m_data  = data_q;
    assign m_eop   = eop_q;
    assign m_valid = valid_q;

endmodule

// File: rtl/m_axis_cq_adapt_128b.sv
// Converts the core's 128-bit CQ stream (descriptor + payload) into a TLP
// stream with a 4-DW header. Unsupported requests are swallowed and counted.
module m_axis_cq_adapt_128b
    import m_axis_cq_adapt_128b_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic [DATA_WIDTH-1:0] m_axis_cq_tdata,
    input  logic [3:0]            m_axis_cq_tkeep,
    input  logic                  m_axis_cq_tlast,
    output logic                  m_axis_cq_tready,
    input  logic [84:0]           m_axis_cq_tuser,
    input  logic                  m_axis_cq_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_cq_tdata_a,
    output logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep_a,
    output logic                  m_axis_cq_tlast_a,
    output logic                  m_axis_cq_tvalid_a,
    input  logic                  m_axis_cq_tready_a,
    output logic [3:0]            m_axis_cq_tuser_a,
    output logic [15:0]           cq_drop_count
);

    cq_state_e    state_q, state_d;
    logic [2:0]   bar_q, bar_d;
    logic [15:0]  drop_cnt_q, drop_cnt_d;

    slice_beat_t  in_beat, sl_beat;
    logic         sl_valid, sl_ready, sl_eop;
    logic         hdr_ok;
    logic [7:0]   hdr_fmt;
    logic [127:0] hdr_data;
    logic [2:0]   desc_bar;
    logic         unused_tuser;

    assign in_beat = '{disc: m_axis_cq_tuser[41], be: m_axis_cq_tuser[7:0],
                       keep: m_axis_cq_tkeep, data: m_axis_cq_tdata};
    assign unused_tuser = ^{m_axis_cq_tuser[84:42], m_axis_cq_tuser[40:8]};

    axis_iff #(
        .W($bits(slice_beat_t))
    ) u_iff (
        .clk    (user_clk),
        .rst    (user_reset),
        .s_data (in_beat),
        .s_eop  (m_axis_cq_tlast),
        .s_valid(m_axis_cq_tvalid),
        .s_ready(m_axis_cq_tready),
        .m_data (sl_beat),
        .m_eop  (sl_eop),
        .m_valid(sl_valid),
        .m_ready(sl_ready)
    );

    assign {hdr_ok, hdr_fmt} = decode_type(sl_beat.data[DESC_TYPE_LSB +: 4]);
    assign desc_bar = sl_beat.data[DESC_BAR_LSB +: 3];

    // Build the 4-DW, 64-bit-address TLP header from the descriptor beat
    always_comb begin
        hdr_data          = '0;
        hdr_data[31:24]   = hdr_fmt;
        hdr_data[22:20]   = sl_beat.data[DESC_TC_LSB +: 3];
        hdr_data[18]      = sl_beat.data[DESC_ATTR_LSB + 2];
        hdr_data[13:12]   = sl_beat.data[DESC_ATTR_LSB +: 2];
        hdr_data[9:0]     = sl_beat.data[DESC_DWCNT_LSB +: 10];
        hdr_data[39:32]   = sl_beat.be;
        hdr_data[47:40]   = sl_beat.data[DESC_TAG_LSB +: 8];
        hdr_data[63:48]   = sl_beat.data[DESC_REQID_LSB +: 16];
        hdr_data[95:64]   = sl_beat.data[63:32];
        hdr_data[127:98]  = sl_beat.data[31:DESC_ADDR_LSB];
    end

    // FSM next state, output remap, bar latch and drop counter
    always_comb begin
        state_d            = state_q;
        bar_d              = bar_q;
        drop_cnt_d         = drop_cnt_q;
        sl_ready           = 1'b0;
        m_axis_cq_tvalid_a = 1'b0;
        m_axis_cq_tdata_a  = sl_beat.data;
        m_axis_cq_tlast_a  = sl_eop;
        m_axis_cq_tuser_a  = {bar_q, sl_beat.disc};
        for (int i = 0; i < 4; i++) begin
            m_axis_cq_tkeep_a[4*i +: 4] = {4{sl_beat.keep[i]}};
        end
        case (state_q)
            ST_HDR: begin
                m_axis_cq_tdata_a = hdr_data;
                m_axis_cq_tkeep_a = '1;
                m_axis_cq_tuser_a = {desc_bar, sl_beat.disc};
                if (hdr_ok) begin
                    m_axis_cq_tvalid_a = sl_valid;
                    sl_ready           = m_axis_cq_tready_a;
                end else begin
                    // unsupported descriptors are swallowed without output
                    sl_ready = 1'b1;
                end
                if (sl_valid && sl_ready) begin
                    bar_d = desc_bar;
                    if (!hdr_ok && drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                    if (!sl_eop) begin
                        state_d = hdr_ok ? ST_DATA : ST_DROP;
                    end
                end
            end
            ST_DATA: begin
                m_axis_cq_tvalid_a = sl_valid;
                sl_ready           = m_axis_cq_tready_a;
                if (sl_valid && sl_ready && sl_eop) begin
                    state_d = ST_HDR;
                end
            end
            ST_DROP: begin
                sl_ready = 1'b1;
                if (sl_valid && sl_eop) begin
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // State, latched bar and drop counter registers
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q    <= ST_HDR;
            bar_q      <= 3'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            bar_q      <= bar_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign cq_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_m_axis_cq_adapt_128b.sv
// Bench for the CQ adapter: randomized packets, reference model producing the
// expected TLP beats into a queue, and a monitor that compares output beats.
module tb_m_axis_cq_adapt_128b;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] tdata;
  logic [3:0]   tkeep;
  logic         tlast;
  logic         tready;
  logic [84:0]  tuser;
  logic         tvalid;
  logic [127:0] tdata_a;
  logic [15:0]  tkeep_a;
  logic         tlast_a;
  logic         tvalid_a;
  logic         tready_a;
  logic [3:0]   tuser_a;
  logic [15:0]  drop_cnt;

  typedef struct {
    logic [3:0]  typ;
    int          dwcnt;
    logic [63:0] addr;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  bar;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
  } req_t;

  // expected beat: {tuser_a, tlast_a, tkeep_a, tdata_a}
  logic [148:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int gap_en = 0;
  int model_drops = 0;

  m_axis_cq_adapt_128b dut (
    .user_clk          (clk),
    .user_reset        (rst),
    .m_axis_cq_tdata   (tdata),
    .m_axis_cq_tkeep   (tkeep),
    .m_axis_cq_tlast   (tlast),
    .m_axis_cq_tready  (tready),
    .m_axis_cq_tuser   (tuser),
    .m_axis_cq_tvalid  (tvalid),
    .m_axis_cq_tdata_a (tdata_a),
    .m_axis_cq_tkeep_a (tkeep_a),
    .m_axis_cq_tlast_a (tlast_a),
    .m_axis_cq_tvalid_a(tvalid_a),
    .m_axis_cq_tready_a(tready_a),
    .m_axis_cq_tuser_a (tuser_a),
    .cq_drop_count     (drop_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [148:0] act, input logic [148:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fmt_of(input logic [3:0] t);
    case (t)
      4'd0: return 32'h20;
      4'd1: return 32'h60;
      4'd7: return 32'h21;
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] keep16(input logic [3:0] k);
    logic [15:0] res;
    res = 16'h0;
    for (int i = 0; i < 4; i++)
      if (k[i]) res = res | (16'hF << (4 * i));
    return res;
  endfunction

  function automatic logic [148:0] model_hdr(input req_t r, input logic disc, input logic last);
    logic [31:0] dw0, dw1, dw2, dw3;
    dw0 = (32'(fmt_of(r.typ)) << 24) | (32'(r.tc) << 20) | (32'(r.attr[2]) << 18)
        | (32'(r.attr[1:0]) << 12) | 32'(r.dwcnt % 1024);
    dw1 = (32'(r.rid) << 16) | (32'(r.tag) << 8) | (32'(r.lbe) << 4) | 32'(r.fbe);
    dw2 = r.addr[63:32];
    dw3 = r.addr[31:0] & ~32'h3;
    return {r.bar, disc, last, 16'hFFFF, dw3, dw2, dw1, dw0};
  endfunction

  function automatic logic [127:0] build_desc(input req_t r);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[63:0]    = r.addr;
    d[74:64]   = 11'(r.dwcnt);
    d[78:75]   = r.typ;
    d[95:80]   = r.rid;
    d[103:96]  = r.tag;
    d[114:112] = r.bar;
    d[123:121] = r.tc;
    d[126:124] = r.attr;
    return d;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.typ   = 4'($urandom);
    r.dwcnt = $urandom_range(1, 1024);
    r.addr  = {$urandom, $urandom};
    r.rid   = 16'($urandom);
    r.tag   = 8'($urandom);
    r.bar   = 3'($urandom);
    r.tc    = 3'($urandom);
    r.attr  = 3'($urandom);
    r.fbe   = 4'($urandom);
    r.lbe   = 4'($urandom);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called and returns at posedge+1; holds the beat until it is accepted.
  task automatic drive_beat(input logic [127:0] d, input logic [3:0] k, input logic l,
                            input logic [84:0] u);
    bit acc;
    tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    tvalid = 1'b0;
    if (gap_en != 0 && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pkt(input req_t r, input int npay, input logic [3:0] last_keep);
    bit ok;
    logic [84:0] u;
    logic [127:0] d;
    logic [3:0] k;
    logic disc, last;
    ok = fmt_of(r.typ) >= 0;
    u = 85'({$urandom, $urandom, $urandom});
    disc = ($urandom_range(0, 7) == 0);
    last = (npay == 0);
    u[7:0] = {r.lbe, r.fbe};
    u[41] = disc;
    if (ok) exp_q.push_back(model_hdr(r, disc, last));
    else if (model_drops < 65535) model_drops++;
    drive_beat(build_desc(r), 4'($urandom), last, u);
    for (int i = 0; i < npay; i++) begin
      last = (i == npay - 1);
      k = last ? last_keep : 4'hF;
      d = {$urandom, $urandom, $urandom, $urandom};
      u = 85'({$urandom, $urandom, $urandom});
      disc = ($urandom_range(0, 7) == 0);
      u[41] = disc;
      if (ok) exp_q.push_back({r.bar, disc, last, keep16(k), d});
      drive_beat(d, k, last, u);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // downstream ready driver
  initial begin
    tready_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tready_a = ($urandom_range(0, 3) != 0);
        1: tready_a = 1'b1;
        default: tready_a = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [148:0] held;
  bit held_v = 1'b0;
  always @(negedge clk) begin
    logic [148:0] act;
    act = {tuser_a, tlast_a, tkeep_a, tdata_a};
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) check("hold_stable", {tvalid_a, act[147:0]}, {1'b1, held[147:0]});
      if (held_v) check("hold_user", 149'(act[148]), 149'(held[148]));
      if (tvalid_a && tready_a) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%h required=none", act);
        end else begin
          check("out_beat", act, exp_q.pop_front());
        end
        held_v = 1'b0;
      end else if (tvalid_a) begin
        held = act;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    req_t r;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 149'({tready, tvalid_a, drop_cnt}), 149'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single-beat MemRd with fixed fields
    r = rand_req();
    r.typ = 4'd0; r.dwcnt = 1; r.addr = 64'h0000_0000_1000_0040; r.tag = 8'h12;
    r.rid = 16'h0100; r.fbe = 4'hF; r.lbe = 4'h0; r.tc = 3'd0; r.attr = 3'd0; r.bar = 3'd0;
    send_pkt(r, 0, 4'hF);
    // MemWr, 4 DW, BAR 2, one payload beat
    r = rand_req(); r.typ = 4'd1; r.dwcnt = 4; r.bar = 3'd2;
    send_pkt(r, 1, 4'hF);
    // MemWr, 1024 DW, 64 payload beats, last keep 3
    r = rand_req(); r.typ = 4'd1; r.dwcnt = 1024;
    send_pkt(r, 64, 4'h3);
    wait_drain();

    // unsupported IORd single beat, then 3-beat type 1000
    r = rand_req(); r.typ = 4'b0010;
    send_pkt(r, 0, 4'hF);
    r = rand_req(); r.typ = 4'b1000;
    send_pkt(r, 2, 4'hF);
    wait_drain();
    check("drop_count_two", 149'(drop_cnt), 149'(model_drops));
    r = rand_req(); r.typ = 4'd0;
    send_pkt(r, 0, 4'hF);
    wait_drain();

    // downstream stall in the middle of a MemWr
    fork
      begin
        req_t rs;
        rs = rand_req(); rs.typ = 4'd1; rs.dwcnt = 32;
        send_pkt(rs, 8, 4'hF);
      end
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 2;
        @(posedge clk);
        @(negedge clk);
        check("stall_full", 149'({tvalid_a, tready}), 149'(2'b10));
        repeat (4) @(posedge clk);
        rdy_mode = 1;
      end
    join
    wait_drain();

    // randomized traffic with random backpressure and input gaps
    rdy_mode = 0;
    gap_en = 1;
    for (int p = 0; p < 40; p++) begin
      r = rand_req();
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0: r.typ = 4'd0;
          1: r.typ = 4'd1;
          default: r.typ = 4'd7;
        endcase
      end
      send_pkt(r, $urandom_range(0, 4), 4'($urandom_range(1, 15)));
    end
    wait_drain();
    check("drop_count_random", 149'(drop_cnt), 149'(model_drops));
    gap_en = 0;

    // reset pulse after the header of a 3-beat MemWr
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    r = rand_req(); r.typ = 4'd1; r.dwcnt = 8;
    drive_beat(build_desc(r), 4'hF, 1'b0, 85'(0));
    @(negedge clk);
    check("pre_reset_valid", 149'(tvalid_a), 149'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("reset_async", 149'({tvalid_a, tready, drop_cnt}), 149'(0));
    exp_q.delete();
    model_drops = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    r = rand_req(); r.typ = 4'd0;
    send_pkt(r, 0, 4'hF);
    r = rand_req(); r.typ = 4'd7;
    send_pkt(r, 1, 4'h1);
    wait_drain();
    check("drop_count_after_reset", 149'(drop_cnt), 149'(model_drops));
    check("queue_empty", 149'(exp_q.size()), 149'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_axis_cq_adapt_128b.md
M_AXIS_CQ_ADAPT_128B -- requirements
Module: m_axis_cq_adapt_128b

Interface
REQ-001 Parameter DATA_WIDTH, default 128, datapath width (only 128 supported).
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8, output byte-keep width.
REQ-003 user_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 user_reset  in  1  reset, asynchronous, active-high.
REQ-005 m_axis_cq_tdata  in  128  core CQ beat: descriptor on the first beat, payload after it.
REQ-006 m_axis_cq_tkeep  in  4  dword keep.
REQ-007 m_axis_cq_tlast  in  1  last beat.
REQ-008 m_axis_cq_tready  out  1  ready to the core.
REQ-009 m_axis_cq_tuser  in  85  [3:0] first_be, [7:4] last_be, [41] discontinue.
REQ-010 m_axis_cq_tvalid  in  1  valid.
REQ-011 m_axis_cq_tdata_a / tkeep_a / tlast_a / tvalid_a  out  128/16/1/1  TLP stream toward LitePCIe.
REQ-012 m_axis_cq_tready_a  in  1  downstream ready.
REQ-013 m_axis_cq_tuser_a  out  4  {bar_id[2:0], discontinue}.
REQ-014 cq_drop_count  out  16  saturating count of dropped requests.

Function
REQ-015 FSM states: HDR (expecting a descriptor beat), DATA (forwarding payload), DROP (discarding payload).
- Transitions are taken only on an accepted beat (valid & ready).
REQ-016 HDR, supported type, tlast=0 -> DATA; HDR, tlast=1 -> HDR; DATA or DROP with tlast=1 -> HDR.
REQ-017 Supported request types, descriptor [78:75] -> fmt/type byte:
- 0000 MemRd -> 8'h20
- 0001 MemWr -> 8'h60
- 0111 LockedRd -> 8'h21
- Any other type is unsupported.
REQ-018 Unsupported descriptor in HDR: beat consumed, no output beat; state -> DROP if tlast=0; cq_drop_count increments, saturating at 16'hFFFF.
REQ-019 Header beat output is a 4-DW header; every request uses the 64-bit-address header form.
- DW0 [31:0]: fmt/type [31:24], attr[2] [18], TC [22:20] from desc [123:121], TD=0, EP=0, attr[1:0] [13:12] from desc [125:124], length [9:0] from dword count [73:64].
- A dword count of 1024 yields a length of 0.
REQ-020 DW1 [63:32]: requester ID = desc [95:80], tag = desc [103:96], last_be = tuser [7:4], first_be = tuser [3:0].
REQ-021 DW2 [95:64] = desc address [63:32]; DW3 [127:96] = {desc [31:2], 2'b00}.
REQ-022 Header beat keep_a = 16'hFFFF; payload keep_a = each tkeep bit replicated x4; payload tdata passes unchanged.
REQ-023 bar_id (desc [114:112]) is latched on the header beat and driven on every beat of that packet; discontinue is passed per beat.
REQ-024 Handshake: an input register slice sits in front of the remap.
- Output valid appears 1 cycle after an input beat is accepted.
- m_axis_cq_tready follows slice occupancy; full throughput is sustained when m_axis_cq_tready_a=1.
- Output beats are held stable while tvalid_a=1 and tready_a=0.
REQ-025 In DROP, the slice output is consumed internally at 1 beat/cycle regardless of m_axis_cq_tready_a, and tvalid_a stays 0.
REQ-026 A discontinue beat with tlast is forwarded unchanged; the FSM returns to HDR.
REQ-027 tlast_a mirrors tlast for forwarded packets.

Reset
REQ-028 While user_reset=1, and on its deassertion:
- FSM = HDR, slice empty, tvalid_a=0, tready=0 during reset, cq_drop_count=0, latched bar_id=0.
REQ-029 Reset mid-packet discards the partial packet; the first beat accepted after reset is decoded as a descriptor.

Structure
REQ-030 The request-type codes, fmt/type bytes and descriptor field bit offsets SHALL live in the shared PHY package.
REQ-031 The input register slice SHALL be the existing axis_iff sub-module: data = {tuser[41], tuser[7:0], tkeep, tdata}, eop = tlast.
- The FSM, remap and counter are local.

Verification
REQ-032 MemRd, addr 64'h0000_0000_1000_0040, dword count 1, tag 8'h12, req ID 16'h0100, first_be F, tlast -> one beat, tlast_a=1:
- DW0=32'h2000_0001, DW1=32'h0100_120F, DW2=32'h0, DW3=32'h1000_0040, keep_a=16'hFFFF.
REQ-033 MemWr, dword count 4, BAR 2, then one payload beat with tkeep 4'hF -> two output beats:
- DW0=32'h6000_0004; payload keep_a=16'hFFFF; tuser_a[3:1]=2 on both beats.
REQ-034 MemWr with dword count 1024 -> length field 0; 64 payload beats forwarded; last beat with tkeep 4'h3 -> keep_a=16'h00FF.
REQ-035 IORd (type 0010) single beat, then a 3-beat type-1000 request -> no output beats, cq_drop_count=2; the next MemRd is forwarded normally.
REQ-036 tready_a held 0 for 5 cycles mid-MemWr -> output data, keep and last stay stable, no beat is lost or duplicated, tready deasserts once the slice is full.
REQ-037 user_reset pulsed after the header beat of a 3-beat MemWr -> outputs reset immediately; the next accepted beat is decoded as a descriptor.
